// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, sequencer states, instruction classes and the control word for control_sequencer.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        RESET, FETCH0, FETCH1, FETCH2, T3, T4, T5, T6, T7, PAUSED, HALTED
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU, CL_MULDIV, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_NOP, CL_HALT, CL_ILL
    } iclass_t;

    typedef struct packed {
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic       pc_out;
        logic       pc_in;
        logic       inc_pc;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       z_lo_out;
        logic       z_hi_out;
        logic       c_out;
        logic       hi_in;
        logic       lo_in;
        logic       read;
        logic       write;
        logic [4:0] alu;
    } ctrl_t;

    function automatic logic writes_ra(iclass_t c);
        return c inside {CL_ALU, CL_IMM, CL_LDI};
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: maps a 5-bit opcode to its instruction class, ALU operation and legality.
module opcode_classifier
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output iclass_t    cls,
    output logic [4:0] alu_op,
    output logic       legal
);

    always_comb begin
        cls    = CL_ILL;
        alu_op = 5'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin cls = CL_ALU;    alu_op = opcode; end
            OP_MUL, OP_DIV:                 begin cls = CL_MULDIV; alu_op = opcode; end
            OP_ADDI:                        begin cls = CL_IMM;    alu_op = OP_ADD; end
            OP_ANDI:                        begin cls = CL_IMM;    alu_op = OP_AND; end
            OP_ORI:                         begin cls = CL_IMM;    alu_op = OP_OR;  end
            OP_LDI:                         begin cls = CL_LDI;    alu_op = OP_ADD; end
            OP_LD:                          begin cls = CL_LD;     alu_op = OP_ADD; end
            OP_ST:                          begin cls = CL_ST;     alu_op = OP_ADD; end
            OP_NOP:                         cls = CL_NOP;
            OP_HALT:                        cls = CL_HALT;
            default: ;
        endcase
    end

    assign legal = cls != CL_ILL;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit stepping T0..T7; CU_SINGLE_STEP_EN adds a step input.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int BITS          = 32,
    parameter int REGISTERS     = 16,
    parameter int REGISTER_BITS = $clog2(REGISTERS)
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef CU_SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic [BITS-1:0] IR,
    input  logic            mem_ready,
    input  logic            stop,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            Cout,
    output logic            HIin,
    output logic            LOin,
    output logic            Read,
    output logic            Write,
    output logic [4:0]      alu_op,
    output logic            run,
    output logic            illegal
);

    state_t     state, state_n, entry;
    iclass_t    cls;
    logic [4:0] cls_alu;
    logic       legal, go;
    ctrl_t      c;
    logic       unused_ir;

    assign unused_ir = ^{IR[BITS-6:0], REGISTER_BITS[0]};

    opcode_classifier u_cls (
        .opcode (IR[BITS-1 -: 5]),
        .cls    (cls),
        .alu_op (cls_alu),
        .legal  (legal)
    );

`ifdef CU_SINGLE_STEP_EN
    logic step_d, step_pend;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_d    <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            step_d    <= step;
            step_pend <= (step & ~step_d) | (step_pend & (state != FETCH0));
        end
    end
    assign go = step_pend;
`else
    assign go = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RESET;
            illegal <= 1'b0;
        end else begin
            state <= state_n;
            if (state == T3 && !legal) illegal <= 1'b1;
        end
    end

    assign entry = stop ? PAUSED : FETCH0;
    assign run   = !(state inside {RESET, PAUSED, HALTED});

    always_comb begin
        state_n = state;
        case (state)
            RESET:   state_n = entry;
            FETCH0:  state_n = go ? FETCH1 : FETCH0;
            FETCH1:  state_n = mem_ready ? FETCH2 : FETCH1;
            FETCH2:  state_n = T3;
            T3:      state_n = cls == CL_HALT ? HALTED : (cls inside {CL_NOP, CL_ILL}) ? entry : T4;
            T4:      state_n = T5;
            T5:      state_n = writes_ra(cls) ? entry : T6;
            T6:      state_n = cls == CL_MULDIV ? entry : (cls == CL_LD && !mem_ready) ? T6 : T7;
            T7:      state_n = (cls == CL_ST && !mem_ready) ? T7 : entry;
            PAUSED:  state_n = stop ? PAUSED : FETCH0;
            HALTED:  state_n = HALTED;
            default: state_n = RESET;
        endcase
    end

    always_comb begin
        c = '0;
        case (state)
            FETCH0: if (go) begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; c.alu = OP_ADD; end
            FETCH1: begin c.z_lo_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
            FETCH2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
            T3: case (cls)
                CL_ALU, CL_IMM:        begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
                CL_MULDIV:             begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
                CL_LDI, CL_LD, CL_ST:  begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
                default: ;
            endcase
            T4: case (cls)
                CL_ALU:                begin c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu = cls_alu; end
                CL_MULDIV:             begin c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu = cls_alu; end
                CL_IMM, CL_LDI,
                CL_LD, CL_ST:          begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu = cls_alu; end
                default: ;
            endcase
            T5: case (cls)
                CL_ALU, CL_IMM, CL_LDI: begin c.z_lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                CL_MULDIV:              begin c.z_lo_out = 1'b1; c.lo_in = 1'b1; end
                CL_LD, CL_ST:           begin c.z_lo_out = 1'b1; c.mar_in = 1'b1; end
                default: ;
            endcase
            T6: case (cls)
                CL_MULDIV: begin c.z_hi_out = 1'b1; c.hi_in = 1'b1; end
                CL_LD:     begin c.read = 1'b1; c.mdr_in = 1'b1; end
                CL_ST:     begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
                default: ;
            endcase
            T7: case (cls)
                CL_LD:   begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
                CL_ST:   c.write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

    assign {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
            Yin, Zin, Zlowout, Zhighout, Cout, HIin, LOin, Read, Write, alu_op} = c;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed tables plus randomized instruction streams checked against a microprogram model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] IR = '0;
    logic        mem_ready = 1'b0;
    logic        stop = 1'b0;
`ifdef CU_SINGLE_STEP_EN
    logic        step = 1'b0;
`endif
    logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
    logic Yin, Zin, Zlowout, Zhighout, Cout, HIin, LOin, Read, Write, run, illegal;
    logic [4:0] alu_op;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .rst_n(rst_n),
`ifdef CU_SINGLE_STEP_EN
        .step(step),
`endif
        .IR(IR), .mem_ready(mem_ready), .stop(stop),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .Cout(Cout),
        .HIin(HIin), .LOin(LOin), .Read(Read), .Write(Write), .alu_op(alu_op), .run(run),
        .illegal(illegal)
    );

    localparam logic [21:0] GRA = 22'd1 << 21, GRB = 22'd1 << 20, GRC = 22'd1 << 19, RIN = 22'd1 << 18;
    localparam logic [21:0] ROUT = 22'd1 << 17, BAOUT = 22'd1 << 16, PCOUT = 22'd1 << 15, PCIN = 22'd1 << 14;
    localparam logic [21:0] INCPC = 22'd1 << 13, MARIN = 22'd1 << 12, MDRIN = 22'd1 << 11, MDROUT = 22'd1 << 10;
    localparam logic [21:0] IRIN = 22'd1 << 9, YIN = 22'd1 << 8, ZIN = 22'd1 << 7, ZLO = 22'd1 << 6;
    localparam logic [21:0] ZHI = 22'd1 << 5, COUT = 22'd1 << 4, HIIN = 22'd1 << 3, LOIN = 22'd1 << 2;
    localparam logic [21:0] RD = 22'd1 << 1, WR = 22'd1;

    wire [21:0] sig = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRout,
                       IRin, Yin, Zin, Zlowout, Zhighout, Cout, HIin, LOin, Read, Write};
    wire [6:0]  bus = {Rout, BAout, PCout, MDRout, Zlowout, Zhighout, Cout};

    int   n_cmp = 0, n_bad = 0;
    logic ill_exp = 1'b0;

    typedef struct { logic [21:0] s; logic [4:0] a; bit w; } step_t;
    step_t plan_q[$];

    typedef struct { logic [4:0] op; int cyc; bit ill; } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cycle_check(input string name, input logic [21:0] es, input logic [4:0] ea, input logic er);
        @(negedge clk);
        check(name, 64'({sig, alu_op, run, illegal}), 64'({es, ea, er, ill_exp}));
        check({name, "_bus"}, 64'($countones(bus) > 1), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic void push(input logic [21:0] s, input logic [4:0] a = 5'd0, input bit w = 1'b0);
        plan_q.push_back('{s, a, w});
    endfunction

    function automatic bit known(input logic [4:0] op);
        return op <= 5'd15 || op == 5'd26 || op == 5'd27;
    endfunction

    function automatic void plan(input logic [4:0] op);
        plan_q.delete();
        push(PCOUT | MARIN | INCPC | ZIN, 5'd3);
        push(ZLO | PCIN | RD | MDRIN, 5'd0, 1'b1);
        push(MDROUT | IRIN);
        if (op >= 5'd3 && op <= 5'd10) begin
            push(GRB | ROUT | YIN); push(GRC | ROUT | ZIN, op); push(ZLO | GRA | RIN);
        end else if (op == 5'd14 || op == 5'd15) begin
            push(GRA | ROUT | YIN); push(GRB | ROUT | ZIN, op); push(ZLO | LOIN); push(ZHI | HIIN);
        end else if (op >= 5'd11 && op <= 5'd13) begin
            push(GRB | ROUT | YIN);
            push(COUT | ZIN, op == 5'd11 ? 5'd3 : op == 5'd12 ? 5'd5 : 5'd6);
            push(ZLO | GRA | RIN);
        end else if (op <= 5'd2) begin
            push(GRB | BAOUT | YIN); push(COUT | ZIN, 5'd3);
            if (op == 5'd1) push(ZLO | GRA | RIN);
            else begin
                push(ZLO | MARIN);
                if (op == 5'd0) begin push(RD | MDRIN, 5'd0, 1'b1); push(MDROUT | GRA | RIN); end
                else begin push(GRA | ROUT | MDRIN); push(WR, 5'd0, 1'b1); end
            end
        end else push(22'd0);
    endfunction

    task automatic release_fetch();
`ifdef CU_SINGLE_STEP_EN
        if (!PCout) begin
            step = 1'b1;
            @(posedge clk);
            #1;
            step = 1'b0;
        end
`endif
    endtask

    task automatic run_instr(input logic [4:0] op, input int dly, input bit stp);
        IR = {op, 27'($urandom)};
        plan(op);
        release_fetch();
        if (stp) stop = 1'b1;
        foreach (plan_q[i]) begin
            if (plan_q[i].w) begin
                int d;
                d = dly < 0 ? int'($urandom_range(0, 4)) : dly;
                for (int k = 0; k <= d; k++) begin
                    mem_ready = (k == d);
                    cycle_check($sformatf("op%0d_t%0d_w%0d", op, i, k), plan_q[i].s, plan_q[i].a, 1'b1);
                end
            end else begin
                mem_ready = 1'($urandom);
                cycle_check($sformatf("op%0d_t%0d", op, i), plan_q[i].s, plan_q[i].a, 1'b1);
            end
            if (i == 3 && !known(op)) ill_exp = 1'b1;
        end
        mem_ready = 1'b0;
    endtask

    task automatic pause_seq();
        repeat (3) cycle_check("paused", 22'd0, 5'd0, 1'b0);
        stop = 1'b0;
        cycle_check("paused_release", 22'd0, 5'd0, 1'b0);
        release_fetch();
        check("resume_fetch", 64'({PCout, MARin, IncPC, run}), 64'hF);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{5'b00011, 6, 1'b0};
        tbl[1]  = '{5'b00100, 6, 1'b0};
        tbl[2]  = '{5'b01001, 6, 1'b0};
        tbl[3]  = '{5'b01011, 6, 1'b0};
        tbl[4]  = '{5'b01101, 6, 1'b0};
        tbl[5]  = '{5'b00001, 6, 1'b0};
        tbl[6]  = '{5'b00000, 8, 1'b0};
        tbl[7]  = '{5'b00010, 8, 1'b0};
        tbl[8]  = '{5'b01110, 7, 1'b0};
        tbl[9]  = '{5'b01111, 7, 1'b0};
        tbl[10] = '{5'b11010, 4, 1'b0};
        tbl[11] = '{5'b11111, 4, 1'b1};

        #1 rst_n = 1'b0;
        #1 check("reset_async", 64'({sig, alu_op, run, illegal}), 64'd0);
        @(posedge clk);
        #1 check("reset_held", 64'({sig, alu_op, run, illegal}), 64'd0);
        IR = {5'b00011, 4'd6, 4'd0, 4'd13, 15'd0};
        mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
`ifndef CU_SINGLE_STEP_EN
        begin
            int edges, seen;
            edges = 0;
            seen = 0;
            while (seen < 2 && edges < 20) begin
                @(posedge clk);
                #1;
                edges++;
                if (PCout) seen++;
            end
            check("add_refetch_edge", 64'(edges), 64'd7);
            check("add_illegal", 64'(illegal), 64'd0);
        end
`else
        @(posedge clk);
        #1;
`endif
        run_instr(5'b00011, -1, 1'b0);

`ifndef CU_SINGLE_STEP_EN
        mem_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            int n;
            IR = {tbl[t].op, 27'($urandom)};
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!PCout && n < 20);
            check($sformatf("cycles_op%0d", tbl[t].op), 64'(n), 64'(tbl[t].cyc));
            check($sformatf("illegal_op%0d", tbl[t].op), 64'(illegal), 64'(tbl[t].ill));
        end
        mem_ready = 1'b0;
        ill_exp = 1'b1;
`else
        run_instr(5'b11111, -1, 1'b0);
`endif
        run_instr(5'b00011, -1, 1'b0);
        run_instr(5'b11011, -1, 1'b0);
        repeat (20) cycle_check("halted", 22'd0, 5'd0, 1'b0);
        rst_n = 1'b0;
        ill_exp = 1'b0;
        #1 check("reset_clears_illegal", 64'({sig, alu_op, run, illegal}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_instr(5'b00000, 3, 1'b0);
        run_instr(5'b00010, 2, 1'b0);

        IR = {5'b00000, 4'd1, 4'd0, 19'd4};
        release_fetch();
        mem_ready = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        check("ld_t6_read", 64'({Read, MDRin, run}), 64'h7);
        #2 rst_n = 1'b0;
        #1 check("reset_in_t6", 64'({sig, alu_op, run, illegal}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        release_fetch();
        check("post_reset_fetch", 64'({PCout, MARin, IncPC, Write, Rin}), 64'h1C);
        run_instr(5'b00011, -1, 1'b0);

        run_instr(5'b01110, -1, 1'b1);
        pause_seq();

`ifdef CU_SINGLE_STEP_EN
        run_instr(5'b11010, -1, 1'b0);
        repeat (3) cycle_check("step_idle", 22'd0, 5'd0, 1'b1);
`endif

        for (int n = 0; n < 150; n++) begin
            logic [4:0] op;
            bit         stp;
            op = 5'($urandom);
            if (op == 5'd27) op = 5'd26;
            stp = ($urandom_range(0, 7) == 0);
            run_instr(op, -1, stp);
            if (stp) pause_seq();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
